// File: rtl/fir_cb_sequencer.sv
// Sequencer for a block-parallel FIR: writes each accepted sample into the circular
// buffer, sweeps buffer/coefficient block addresses and issues aligned MAC strobes.
module fir_cb_sequencer #(
  parameter int AW      = 11,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          smp_valid,
  input  logic [17:0]   smp_data,
  input  logic [AW-1:0] nblk,
  input  logic          ovr_clr,
  output logic          smp_ready,
  output logic          buf_wen,
  output logic [17:0]   buf_din,
  output logic [AW-1:0] buf_addrin,
  output logic [AW-1:0] coef_addr,
  output logic          mac_en,
  output logic          mac_first,
  output logic          mac_last,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, WRITE, SWEEP, DRAIN} state_t;

  localparam int CW = $clog2(MAC_LAT + 2);

  state_t          state, state_d;
  logic [AW-1:0]   addr, addr_d, addr_inc;
  logic [AW-1:0]   lastblk, lastblk_d;
  logic            wen_d;
  logic [17:0]     din_d;
  logic            issue, issue_d;
  logic            first, first_d;
  logic            last, last_d;
  logic [RD_LAT-1:0] en_sr, first_sr, last_sr;
  logic [CW-1:0]   cnt, cnt_d;
  logic            done_d, ovr_d;

  assign smp_ready  = (state == IDLE);
  assign buf_addrin = addr;
  assign coef_addr  = addr;
  assign mac_en     = en_sr[RD_LAT-1];
  assign mac_first  = first_sr[RD_LAT-1];
  assign mac_last   = last_sr[RD_LAT-1];
  assign addr_inc   = addr + AW'(1);

  always_comb begin
    state_d   = state;
    addr_d    = addr;
    lastblk_d = lastblk;
    wen_d     = 1'b0;
    din_d     = buf_din;
    issue_d   = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    cnt_d     = cnt;
    done_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (smp_valid) begin
          state_d   = WRITE;
          wen_d     = 1'b1;
          din_d     = smp_data;
          lastblk_d = nblk;
          addr_d    = '0;
        end
      end
      WRITE: begin
        state_d = SWEEP;
        issue_d = 1'b1;
        first_d = 1'b1;
        last_d  = (lastblk == '0);
      end
      SWEEP: begin
        // Increment is only taken below lastblk, so lastblk = all-ones cannot wrap.
        if (addr == lastblk) begin
          state_d = DRAIN;
        end else begin
          addr_d  = addr_inc;
          issue_d = 1'b1;
          last_d  = (addr_inc == lastblk);
        end
      end
      DRAIN: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counts the MAC pipeline latency after the final block leaves the read delay line.
    if (mac_last)
      cnt_d = CW'(MAC_LAT);
    else if (cnt != '0)
      cnt_d = cnt - CW'(1);

    if (state == DRAIN)
      done_d = (MAC_LAT == 0) ? mac_last : (cnt == CW'(1));

    if (smp_valid && (state != IDLE))
      ovr_d = 1'b1;
    else if (ovr_clr)
      ovr_d = 1'b0;
    else
      ovr_d = overrun;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      lastblk  <= '0;
      buf_wen  <= 1'b0;
      buf_din  <= '0;
      issue    <= 1'b0;
      first    <= 1'b0;
      last     <= 1'b0;
      en_sr    <= '0;
      first_sr <= '0;
      last_sr  <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state       <= state_d;
      addr        <= addr_d;
      lastblk     <= lastblk_d;
      buf_wen     <= wen_d;
      buf_din     <= din_d;
      issue       <= issue_d;
      first       <= first_d;
      last        <= last_d;
      en_sr[0]    <= issue;
      first_sr[0] <= first;
      last_sr[0]  <= last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        en_sr[i]    <= en_sr[i-1];
        first_sr[i] <= first_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end
      cnt     <= cnt_d;
      done    <= done_d;
      overrun <= ovr_d;
    end
  end

endmodule
